// File: rtl/text_char_renderer_pkg.sv
// Shared geometry, widths and pipeline payload for the text-mode renderer.
package text_pkg;

  localparam int unsigned CHAR_W           = 8;
  localparam int unsigned CHAR_H           = 16;
  localparam int unsigned COLS             = 80;
  localparam int unsigned ROWS             = 30;
  localparam int unsigned TXT_AW           = 12;
  localparam int unsigned FONT_AW          = 12;
  localparam int unsigned RGB_W            = 12;
  localparam int unsigned CURSOR_FIRST_ROW = 14;
  localparam int unsigned PIX_W            = 10;
  localparam int unsigned COL_W            = 7;
  localparam int unsigned ROW_W            = 5;
  localparam int unsigned XLO_W            = 3;
  localparam int unsigned YLO_W            = 4;

  // Per-pixel state carried from the address cycle to the dot-select cycle.
  typedef struct packed {
    logic [XLO_W-1:0] x_lo;
    logic [YLO_W-1:0] y_lo;
    logic             video_on;
    logic             hs;
    logic             vs;
    logic             in_range;
    logic             cursor_hit;
  } pix_s1_t;

  // row*80 + col built from shifts so no multiplier is inferred.
  function automatic logic [TXT_AW-1:0] cell_addr(input logic [ROW_W-1:0] row,
                                                  input logic [COL_W-1:0] col);
    return (TXT_AW'(row) << 6) + (TXT_AW'(row) << 4) + TXT_AW'(col);
  endfunction

endpackage

// File: rtl/text_char_renderer_cursor_blink.sv
// Cursor blink timer: counts vsync falling edges and toggles the blink phase.
module cursor_blink
  import text_pkg::*;
#(
  parameter int unsigned BLINK_FRAMES = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic vs_in,
  output logic blink_phase
);

  localparam int unsigned CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic             vs_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             phase_q, phase_d;
  logic             frame_evt_c;

  // Frame event on vsync going low relative to last cycle's sample.
  assign frame_evt_c = vs_q & ~vs_in;

  // Next-state for the frame counter and blink phase.
  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (frame_evt_c) begin
      if (cnt_q == CNT_W'(BLINK_FRAMES - 1)) begin
        cnt_d   = '0;
        phase_d = ~phase_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // State registers; cursor starts visible out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_q    <= 1'b0;
      cnt_q   <= '0;
      phase_q <= 1'b1;
    end else begin
      vs_q    <= vs_in;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign blink_phase = phase_q;

endmodule

// File: rtl/text_char_renderer.sv
// Text-mode pixel generator: cell lookup, font fetch, dot select, cursor, 2-cycle sync delay.
module text_char_renderer
  import text_pkg::*;
#(
  parameter int unsigned      COLS         = 80,
  parameter int unsigned      ROWS         = 30,
  parameter logic [RGB_W-1:0] FG_RGB       = 12'hFFF,
  parameter logic [RGB_W-1:0] BG_RGB       = 12'h000,
  parameter int unsigned      BLINK_FRAMES = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [PIX_W-1:0]   pix_x,
  input  logic [PIX_W-1:0]   pix_y,
  input  logic               video_on,
  input  logic               hs_in,
  input  logic               vs_in,
  input  logic               cursor_en,
  input  logic [COL_W-1:0]   cursor_col,
  input  logic [ROW_W-1:0]   cursor_row,
  output logic [TXT_AW-1:0]  txt_addr,
  input  logic [7:0]         txt_data,
  output logic [FONT_AW-1:0] font_addr,
  input  logic [7:0]         font_data,
  output logic [RGB_W-1:0]   rgb,
  output logic               hs_out,
  output logic               vs_out
);

  logic [COL_W-1:0] col_c;
  logic [ROW_W-1:0] row_c;
  logic             cursor_ok_c;
  logic             unused_pix_y_msb;
  pix_s1_t          s1_q, s1_d;
  logic             blink_phase;
  logic             dot_c;
  logic [RGB_W-1:0] rgb_q, rgb_d;
  logic             hs_q, vs_q;

  assign col_c            = pix_x[9:3];
  assign row_c            = pix_y[8:4];
  assign unused_pix_y_msb = pix_y[9];
  assign txt_addr         = cell_addr(row_c, col_c);

  // A cursor parked outside the text grid must never light a cell.
  assign cursor_ok_c = (cursor_col < COL_W'(COLS)) && (cursor_row < ROW_W'(ROWS));

  // Stage-1 payload captured alongside the text RAM read.
  always_comb begin
    s1_d            = '0;
    s1_d.x_lo       = pix_x[2:0];
    s1_d.y_lo       = pix_y[3:0];
    s1_d.video_on   = video_on;
    s1_d.hs         = hs_in;
    s1_d.vs         = vs_in;
    s1_d.in_range   = (col_c < COL_W'(COLS)) && (row_c < ROW_W'(ROWS));
    s1_d.cursor_hit = cursor_en && cursor_ok_c && (col_c == cursor_col) &&
                      (row_c == cursor_row) && (pix_y[3:0] >= YLO_W'(CURSOR_FIRST_ROW));
  end

  cursor_blink #(
    .BLINK_FRAMES(BLINK_FRAMES)
  ) u_blink (
    .clk         (clk),
    .rst_n       (rst_n),
    .vs_in       (vs_in),
    .blink_phase (blink_phase)
  );

  assign font_addr = {txt_data, s1_q.y_lo};
  assign dot_c     = font_data[XLO_W'(CHAR_W - 1) - s1_q.x_lo];

  // Pixel colour: blanking first, then off-grid background, then glyph/cursor.
  always_comb begin
    rgb_d = BG_RGB;
    if (!s1_q.video_on) begin
      rgb_d = '0;
    end else if (!s1_q.in_range) begin
      rgb_d = BG_RGB;
    end else if ((s1_q.cursor_hit && blink_phase) || dot_c) begin
      rgb_d = FG_RGB;
    end
  end

  // Pipeline and output registers; syncs idle high so reset reads as inactive.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= '0;
      s1_q.hs <= 1'b1;
      s1_q.vs <= 1'b1;
      rgb_q   <= '0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
    end else begin
      s1_q  <= s1_d;
      rgb_q <= rgb_d;
      hs_q  <= s1_q.hs;
      vs_q  <= s1_q.vs;
    end
  end

  assign rgb    = rgb_q;
  assign hs_out = hs_q;
  assign vs_out = vs_q;

endmodule

// File: tb/tb_text_char_renderer.sv
// Scoreboard bench for text_char_renderer with behavioural text RAM and font ROM.
module tb_text_char_renderer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  pix_x, pix_y;
  logic        video_on, hs_in, vs_in, cursor_en;
  logic [6:0]  cursor_col;
  logic [4:0]  cursor_row;
  logic [11:0] txt_addr, font_addr, rgb;
  logic [7:0]  txt_data, font_data;
  logic        hs_out, vs_out;

  logic [7:0] ram [0:4095];
  logic [7:0] rom [0:4095];

  typedef struct {
    int          due;
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous text RAM and combinational font ROM.
  always @(posedge clk) txt_data <= ram[txt_addr];
  assign font_data = rom[font_addr];

  text_char_renderer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .video_on   (video_on),
    .hs_in      (hs_in),
    .vs_in      (vs_in),
    .cursor_en  (cursor_en),
    .cursor_col (cursor_col),
    .cursor_row (cursor_row),
    .txt_addr   (txt_addr),
    .txt_data   (txt_data),
    .font_addr  (font_addr),
    .font_data  (font_data),
    .rgb        (rgb),
    .hs_out     (hs_out),
    .vs_out     (vs_out)
  );

  // Monitor: pops every expectation whose output cycle has arrived.
  always @(negedge clk) begin
    exp_t e;
    while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
      e = sb_q.pop_front();
      checks++;
      if (e.due != cyc || rgb !== e.rgb || hs_out !== e.hs || vs_out !== e.vs) begin
        errors++;
        $display("FAIL pix_out cyc=%0d due=%0d: got rgb=%h hs=%b vs=%b, want rgb=%h hs=%b vs=%b",
                 cyc, e.due, rgb, hs_out, vs_out, e.rgb, e.hs, e.vs);
      end
    end
  end

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  // One pixel per call; called just after a rising edge, returns just after the next.
  task automatic drive_pix(input int x, input int y, input logic von, input logic h,
                           input logic v, input logic [11:0] exp_rgb, input int exp_txt = -1);
    pix_x    = 10'(x);
    pix_y    = 10'(y);
    video_on = von;
    hs_in    = h;
    vs_in    = v;
    sb_q.push_back('{due: cyc + 2, rgb: exp_rgb, hs: h, vs: v});
    if (exp_txt >= 0) begin
      #1;
      check("txt_addr", int'(txt_addr), exp_txt);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic frame_edges(input int n);
    for (int i = 0; i < n; i++) begin
      drive_pix(0, 0, 1'b0, 1'b1, 1'b0, 12'h000);
      drive_pix(0, 0, 1'b0, 1'b1, 1'b1, 12'h000);
    end
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    sb_q.delete();
    #1;
    check("rst_rgb", int'(rgb), 0);
    check("rst_hs", int'(hs_out), 1);
    check("rst_vs", int'(vs_out), 1);
    @(posedge clk);
    #1;
    check("rst_hold_rgb", int'(rgb), 0);
    rst_n = 1'b1;
    sb_q.push_back('{due: cyc + 1, rgb: 12'h000, hs: 1'b1, vs: 1'b1});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4096; i++) begin
      ram[i] = 8'h00;
      rom[i] = 8'h00;
    end
    ram[162]      = 8'h41;
    ram[247]      = 8'h41;
    ram[2399]     = 8'h7E;
    rom[12'h413]  = 8'b0010_0000;
    rom[12'h7EF]  = 8'b0000_0001;

    rst_n = 1'b0; pix_x = '0; pix_y = '0; video_on = 1'b0;
    hs_in = 1'b0; vs_in = 1'b0; cursor_en = 1'b0; cursor_col = '0; cursor_row = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Live traffic with syncs low, then asynchronous reset mid-cycle.
    repeat (3) drive_pix(18, 35, 1'b1, 1'b0, 1'b0, 12'hFFF);
    reset_pulse();

    // Glyph lookup and dot select.
    drive_pix(18, 35, 1'b1, 1'b1, 1'b1, 12'hFFF, 162);
    check("font_addr_a", int'(font_addr), 12'h413);
    drive_pix(17, 35, 1'b1, 1'b1, 1'b1, 12'h000, 162);
    check("font_addr_b", int'(font_addr), 12'h413);
    drive_pix(18, 35, 1'b0, 1'b1, 1'b1, 12'h000);

    // Grid corners and off-grid pixels.
    drive_pix(639, 479, 1'b1, 1'b1, 1'b1, 12'hFFF, 2399);
    check("font_addr_corner", int'(font_addr), 12'h7EF);
    drive_pix(698, 35, 1'b1, 1'b1, 1'b1, 12'h000, 247);
    drive_pix(800, 500, 1'b0, 1'b1, 1'b1, 12'h000);

    // Cursor placement.
    cursor_en = 1'b1; cursor_col = 7'd2; cursor_row = 5'd2;
    drive_pix(18, 46, 1'b1, 1'b1, 1'b1, 12'hFFF, 162);
    check("font_addr_cur", int'(font_addr), 12'h41E);
    drive_pix(18, 44, 1'b1, 1'b1, 1'b1, 12'h000);
    drive_pix(26, 46, 1'b1, 1'b1, 1'b1, 12'h000);
    cursor_col = 7'd100;
    drive_pix(800, 46, 1'b1, 1'b1, 1'b1, 12'h000);
    cursor_col = 7'd2;

    // Blink: phase flips on the 32nd frame and back on the 64th.
    frame_edges(31);
    drive_pix(18, 46, 1'b1, 1'b1, 1'b1, 12'hFFF);
    frame_edges(1);
    drive_pix(18, 46, 1'b1, 1'b1, 1'b1, 12'h000);
    frame_edges(32);
    drive_pix(18, 46, 1'b1, 1'b1, 1'b1, 12'hFFF);
    cursor_en = 1'b0;
    drive_pix(18, 46, 1'b1, 1'b1, 1'b1, 12'h000);
    cursor_en = 1'b1;

    // Sync delay: 96-clock hsync pulse then a 5-clock vsync pulse (one frame edge).
    repeat (4)  drive_pix(0, 0, 1'b0, 1'b1, 1'b1, 12'h000);
    repeat (96) drive_pix(0, 0, 1'b0, 1'b0, 1'b1, 12'h000);
    repeat (4)  drive_pix(0, 0, 1'b0, 1'b1, 1'b1, 12'h000);
    repeat (5)  drive_pix(0, 0, 1'b0, 1'b1, 1'b0, 12'h000);
    repeat (2)  drive_pix(0, 0, 1'b0, 1'b1, 1'b1, 12'h000);

    // Hide the cursor, advance 10 frames, then reset mid-frame.
    frame_edges(31);
    frame_edges(10);
    repeat (2) drive_pix(18, 46, 1'b1, 1'b1, 1'b1, 12'h000);
    reset_pulse();
    drive_pix(18, 46, 1'b1, 1'b1, 1'b1, 12'hFFF);
    frame_edges(31);
    drive_pix(18, 46, 1'b1, 1'b1, 1'b1, 12'hFFF);
    frame_edges(1);
    drive_pix(18, 46, 1'b1, 1'b1, 1'b1, 12'h000);

    repeat (3) drive_pix(0, 0, 1'b0, 1'b1, 1'b1, 12'h000);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sb_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
